// File: rtl/key_event_dispatcher.sv
// Key event dispatcher: synchronises PS/2 completions, filters game keys into a FIFO,
// and hands events one at a time to the P1, P2 or system consumer over valid/ready.
module key_event_dispatcher #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  KEY_P1_LEFT  = 8'h1C,
    parameter logic [7:0]  KEY_P1_RIGHT = 8'h23,
    parameter logic [7:0]  KEY_P2_LEFT  = 8'h3B,
    parameter logic [7:0]  KEY_P2_RIGHT = 8'h4B,
    parameter logic [7:0]  KEY_SPACE    = 8'h29,
    parameter logic [7:0]  KEY_ESC      = 8'h76,
    parameter logic [7:0]  KEY_1        = 8'h16,
    parameter logic [7:0]  KEY_2        = 8'h1E
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            key_done,
    input  logic [7:0]                      key_code,
    input  logic                            two_player,
    output logic                            p1_valid,
    output logic                            p1_dir,
    input  logic                            p1_ready,
    output logic                            p2_valid,
    output logic                            p2_dir,
    input  logic                            p2_ready,
    output logic                            sys_valid,
    output logic [1:0]                      sys_cmd,
    input  logic                            sys_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      overflow_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t        r_state, w_next_state;
    logic          r_s1, r_s2, r_s3;
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_out;
    logic [7:0]    r_ovf;

    logic          w_edge, w_rec, w_full, w_empty, w_push, w_drop, w_pop, w_xfer;
    logic [3:0]    w_entry;
    logic [1:0]    w_dest;

    assign w_edge  = r_s2 & ~r_s3;
    assign w_full  = (r_count == FIFO_DEPTH[AW:0]);
    assign w_empty = (r_count == '0);
    assign w_push  = w_edge & w_rec & ~w_full;
    assign w_drop  = w_edge & w_rec & w_full;
    assign w_dest  = r_out[3:2];

    // Synchroniser flops reset high so key_done held across reset release gives no edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= key_done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_rec   = 1'b0;
        w_entry = '0;
        if (key_code == KEY_P1_LEFT) begin
            w_rec = 1'b1; w_entry = 4'b0100;
        end else if (key_code == KEY_P1_RIGHT) begin
            w_rec = 1'b1; w_entry = 4'b0101;
        end else if (key_code == KEY_P2_LEFT) begin
            w_rec = two_player; w_entry = 4'b1000;
        end else if (key_code == KEY_P2_RIGHT) begin
            w_rec = two_player; w_entry = 4'b1001;
        end else if (key_code == KEY_SPACE) begin
            w_rec = 1'b1; w_entry = 4'b1100;
        end else if (key_code == KEY_ESC) begin
            w_rec = 1'b1; w_entry = 4'b1101;
        end else if (key_code == KEY_1) begin
            w_rec = 1'b1; w_entry = 4'b1110;
        end else if (key_code == KEY_2) begin
            w_rec = 1'b1; w_entry = 4'b1111;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= w_entry;
    end

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never admits a push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            r_out   <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_out  <= r_mem[r_rptr];
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            if (w_drop && r_ovf != 8'hFF)
                r_ovf <= r_ovf + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_xfer) begin
                    if (!w_empty)
                        w_pop = 1'b1;
                    else
                        w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        p1_valid  = (r_state == S_HOLD) && (w_dest == 2'd1);
        p2_valid  = (r_state == S_HOLD) && (w_dest == 2'd2);
        sys_valid = (r_state == S_HOLD) && (w_dest == 2'd3);
        p1_dir    = p1_valid & r_out[0];
        p2_dir    = p2_valid & r_out[0];
        sys_cmd   = sys_valid ? r_out[1:0] : 2'b00;
        w_xfer    = (p1_valid & p1_ready) | (p2_valid & p2_ready) | (sys_valid & sys_ready);
    end

    assign fifo_level     = r_count;
    assign overflow_count = r_ovf;

endmodule

// File: tb/tb_key_event_dispatcher.sv
// Scoreboard bench for key_event_dispatcher: directed key sequences push expected
// {dest,arg} entries; a negedge monitor checks every handshake transfer against them.
module tb_key_event_dispatcher;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_done = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       two_player = 1'b1;
    logic       p1_valid, p1_dir, p1_ready = 1'b1;
    logic       p2_valid, p2_dir, p2_ready = 1'b1;
    logic       sys_valid, sys_ready = 1'b1;
    logic [1:0] sys_cmd;
    logic [2:0] fifo_level;
    logic [7:0] overflow_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [3:0]  exp_q [$];

    key_event_dispatcher #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .key_done(key_done), .key_code(key_code),
        .two_player(two_player),
        .p1_valid(p1_valid), .p1_dir(p1_dir), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_dir(p2_dir), .p2_ready(p2_ready),
        .sys_valid(sys_valid), .sys_cmd(sys_cmd), .sys_ready(sys_ready),
        .fifo_level(fifo_level), .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Monitor: payload ordering, one-hot valids, and payload stability while stalled.
    logic       prev_hold = 1'b0;
    logic [3:0] prev_pay  = '0;
    always @(negedge clock) begin
        logic [3:0] act;
        logic       any, xfer;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            any  = p1_valid | p2_valid | sys_valid;
            xfer = (p1_valid & p1_ready) | (p2_valid & p2_ready) | (sys_valid & sys_ready);
            act  = p1_valid ? {3'b010, p1_dir} : p2_valid ? {3'b100, p2_dir} : {2'b11, sys_cmd};
            if (any)
                check("onehot_valid", int'(p1_valid) + int'(p2_valid) + int'(sys_valid), 1);
            if (prev_hold) begin
                check("hold_valid", int'(any), 1);
                check("hold_payload", int'(act), int'(prev_pay));
            end
            if (xfer) begin
                if (exp_q.size() == 0)
                    check("unexpected_event", int'(act), 0);
                else
                    check("event_payload", int'(act), int'(exp_q.pop_front()));
            end
            prev_hold = any & ~xfer;
            prev_pay  = act;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse key_done for 6 clocks then low for 2: 8 clocks per key.
    task automatic send(input logic [7:0] code, input logic expect_ev, input logic [3:0] ev);
        key_code = code;
        key_done = 1'b1;
        if (expect_ev)
            exp_q.push_back(ev);
        repeat (6) tick();
        key_done = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int lat;
        int seen;
        int hi;

        // Reset state
        #2;
        check("rst_p1_valid", int'(p1_valid), 0);
        check("rst_sys_valid", int'(sys_valid), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow_count), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Test 1: single P1-left, latency 4 clocks, one-cycle valid
        key_code = 8'h1C;
        key_done = 1'b1;
        exp_q.push_back(4'b0100);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (p1_valid && lat == 0) lat = k;
        end
        check("t1_latency", lat, 4);
        check("t1_fifo_level", int'(fifo_level), 0);
        check("t1_p1_valid_after", int'(p1_valid), 0);
        key_done = 1'b0;
        repeat (3) tick();

        // Test 2: system event stalled for 20 cycles, then accepted
        sys_ready = 1'b0;
        send(8'h29, 1'b1, 4'b1100);
        seen = 0;
        for (int k = 0; k < 20 && !sys_valid; k++) tick();
        check("t2_sys_valid_seen", int'(sys_valid), 1);
        repeat (20) tick();
        check("t2_sys_valid_held", int'(sys_valid), 1);
        check("t2_sys_cmd", int'(sys_cmd), 0);
        sys_ready = 1'b1;
        tick();
        check("t2_sys_valid_drop", int'(sys_valid), 0);

        // Test 3: overflow and back-to-back flush
        p1_ready = 1'b0; p2_ready = 1'b0; sys_ready = 1'b0;
        send(8'h1C, 1'b1, 4'b0100);
        send(8'h23, 1'b1, 4'b0101);
        send(8'h3B, 1'b1, 4'b1000);
        send(8'h29, 1'b1, 4'b1100);
        send(8'h76, 1'b1, 4'b1101);
        send(8'h16, 1'b0, 4'b0000);
        repeat (4) tick();
        check("t3_fifo_level", int'(fifo_level), 4);
        check("t3_overflow", int'(overflow_count), 1);
        check("t3_p1_head", int'(p1_valid), 1);
        p1_ready = 1'b1; p2_ready = 1'b1; sys_ready = 1'b1;
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (p1_valid | p2_valid | sys_valid) hi++;
        end
        check("t3_back_to_back", hi, 5);
        @(negedge clock);
        check("t3_drained_valid", int'(p1_valid | p2_valid | sys_valid), 0);
        check("t3_drained_level", int'(fifo_level), 0);
        check("t3_queue_empty", exp_q.size(), 0);
        tick();

        // Test 4: P2 keys filtered in single-player mode
        two_player = 1'b0;
        send(8'h4B, 1'b0, 4'b0000);
        repeat (4) tick();
        check("t4_no_level", int'(fifo_level), 0);
        check("t4_no_p2", int'(p2_valid), 0);
        two_player = 1'b1;
        send(8'h4B, 1'b1, 4'b1001);
        repeat (4) tick();
        check("t4_queue_empty", exp_q.size(), 0);

        // Test 5: unknown code dropped silently, ESC delivered
        do_reset();
        send(8'h15, 1'b0, 4'b0000);
        repeat (4) tick();
        check("t5_no_level", int'(fifo_level), 0);
        send(8'h76, 1'b1, 4'b1101);
        repeat (4) tick();
        check("t5_overflow", int'(overflow_count), 0);
        check("t5_queue_empty", exp_q.size(), 0);

        // Test 6: reset while valid with key_done held high across release
        p1_ready = 1'b0;
        key_code = 8'h1C;
        key_done = 1'b1;
        for (int k = 0; k < 20 && !p1_valid; k++) tick();
        check("t6_p1_valid_seen", int'(p1_valid), 1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t6_p1_valid_async", int'(p1_valid), 0);
        check("t6_fifo_level", int'(fifo_level), 0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (p1_valid | p2_valid | sys_valid) seen = 1;
        end
        check("t6_no_event", seen, 0);
        check("t6_level_after", int'(fifo_level), 0);
        key_done = 1'b0;
        p1_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
